// File: rtl/pipeline_flow_ctrl_pkg.sv
// pipeline_flow_ctrl_pkg: shared defaults and width helpers for the pipeline flow controller
package pipeline_flow_ctrl_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NOF_STAGES = 4;
    localparam int MAX_NOF_STAGES = 64;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipeline_out_fifo.sv
// pipeline_out_fifo: output buffer catching pipeline data; any depth, pointers wrap modulo DEPTH
module pipeline_out_fifo
    import pipeline_flow_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_NOF_STAGES + 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          data_o,
    output logic [cnt_w(DEPTH)-1:0]   cnt_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             wr_en, rd_en;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rd_en   = pop_i & !empty_o;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign wr_en   = push_i & (!full_o | rd_en);
    assign cnt_o   = cnt_q;
    assign data_o  = mem[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= nxt(wr_q);
            if (rd_en) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en & !clr_i) mem[wr_q] <= data_i;
    end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: credit-based valid/ready wrapper around a fixed-latency, non-stalling pipeline
module pipeline_flow_ctrl
    import pipeline_flow_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NOF_STAGES = DEF_NOF_STAGES,
    parameter int FIFO_DEPTH = NOF_STAGES + 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic [WIDTH-1:0] pipe_data_o,
    input  logic [WIDTH-1:0] pipe_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam int CW = cnt_w(FIFO_DEPTH);

    if (FIFO_DEPTH < 1 || NOF_STAGES < 1 || NOF_STAGES > MAX_NOF_STAGES) begin : g_param_chk
        $error("pipeline_flow_ctrl: need FIFO_DEPTH >= 1 and 1 <= NOF_STAGES <= 64");
    end

    logic [NOF_STAGES-1:0] vld_sr;
    logic [CW-1:0]         inflight_q, fifo_cnt;
    logic                  accept, push, pop, fifo_full, fifo_empty;

    // every beat in flight owns a FIFO slot, so the FIFO can never be overrun
    assign s_ready_o   = rst_ni & !flush_i & (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH));
    assign accept      = s_valid_i & s_ready_o;
    assign push        = vld_sr[NOF_STAGES-1];
    assign m_valid_o   = !fifo_empty;
    assign pop         = m_valid_o & m_ready_i;
    assign pipe_data_o = accept ? s_data_i : '0;
    assign busy_o      = |vld_sr | !fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_sr     <= '0;
            inflight_q <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= overflow_o | (push & fifo_full & !pop & !flush_i);
            if (flush_i) begin
                vld_sr     <= '0;
                inflight_q <= '0;
            end else begin
                vld_sr     <= (vld_sr << 1) | NOF_STAGES'(accept);
                inflight_q <= inflight_q + CW'(accept) - CW'(push);
            end
        end
    end

    pipeline_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush_i),
        .push_i  (push),
        .data_i  (pipe_data_i),
        .pop_i   (pop),
        .data_o  (m_data_o),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// tb_pipeline_flow_ctrl: two configurations (4 stages/6 entries, 1 stage/2 entries) on shared stimulus
module tb_pipeline_flow_ctrl;

    logic       clk = 1'b0, rst_n = 1'b1, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready [2], m_valid [2], busy [2], ovf [2];
    logic [7:0] m_data [2], pipe_o [2], pipe_i [2];

    int         vectors = 0, miscompares = 0, cyc = 0;
    logic [7:0] fq [2][$];
    logic [7:0] iq [2][$];
    int         ia [2][$];
    logic [7:0] rx [2][$];
    logic [7:0] sent [$];
    logic       eovf [2] = '{1'b0, 1'b0};
    logic       acc_seen [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int NS = (k == 0) ? 4 : 1;
        localparam int FD = (k == 0) ? 6 : 2;
        logic [7:0] pl [NS];
        // stand-in for the free-running data path: pure NS-cycle delay
        always @(posedge clk) begin
            pl[0] <= pipe_o[k];
            for (int i = 1; i < NS; i++) pl[i] <= pl[i-1];
        end
        assign pipe_i[k] = pl[NS-1];
        pipeline_flow_ctrl #(.WIDTH(8), .NOF_STAGES(NS), .FIFO_DEPTH(FD)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .flush_i     (flush),
            .s_valid_i   (s_valid),
            .s_ready_o   (s_ready[k]),
            .s_data_i    (s_data),
            .pipe_data_o (pipe_o[k]),
            .pipe_data_i (pipe_i[k]),
            .m_valid_o   (m_valid[k]),
            .m_ready_i   (m_ready),
            .m_data_o    (m_data[k]),
            .busy_o      (busy[k]),
            .overflow_o  (ovf[k])
        );
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // one clock: compare at the falling edge against the transaction model, then advance it
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int   ns, fd;
            logic er, ea, ep;
            ns = (k == 0) ? 4 : 1;
            fd = (k == 0) ? 6 : 2;
            if (!rst_n) begin
                fq[k].delete();
                iq[k].delete();
                ia[k].delete();
                eovf[k] = 1'b0;
            end
            er = rst_n && !flush && (iq[k].size() + fq[k].size() < fd);
            ea = s_valid && er;
            ep = (fq[k].size() != 0) && m_ready;
            check("s_ready", k, s_ready[k], er);
            check("m_valid", k, m_valid[k], fq[k].size() != 0);
            if (fq[k].size() != 0) check("m_data", k, m_data[k], fq[k][0]);
            check("busy", k, busy[k], (iq[k].size() + fq[k].size()) != 0);
            check("overflow", k, ovf[k], eovf[k]);
            check("pipe_data", k, pipe_o[k], ea ? s_data : 8'h00);
            acc_seen[k] = s_valid && s_ready[k];
            if (m_valid[k] && m_ready) rx[k].push_back(m_data[k]);
            if (rst_n && flush) begin
                fq[k].delete();
                iq[k].delete();
                ia[k].delete();
            end else if (rst_n) begin
                if (ep) void'(fq[k].pop_front());
                if (iq[k].size() != 0 && ia[k][0] == ns) begin
                    if (fq[k].size() == fd) eovf[k] = 1'b1;
                    else fq[k].push_back(iq[k][0]);
                    void'(iq[k].pop_front());
                    void'(ia[k].pop_front());
                end
                foreach (ia[k][i]) ia[k][i]++;
                if (ea) begin
                    iq[k].push_back(s_data);
                    ia[k].push_back(1);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stream(input int sel, input int n, input int vpct, input int rpct, input bit rnd,
                          input logic [7:0] base, input int maxc, output int acc, output int cycles, output int stalls);
        logic [7:0] d;
        acc = 0;
        cycles = 0;
        stalls = 0;
        d = rnd ? 8'($urandom) : base;
        while (acc < n && cycles < maxc) begin
            s_data  = d;
            s_valid = $urandom_range(99) < vpct;
            m_ready = $urandom_range(99) < rpct;
            step();
            cycles++;
            if (s_valid && !acc_seen[sel]) stalls++;
            if (acc_seen[sel]) begin
                sent.push_back(d);
                acc++;
                d = rnd ? 8'($urandom) : base + 8'(acc);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((busy[0] || busy[1]) && c < 300) begin
            step();
            c++;
        end
        check("drain_idle", 0, busy[0] | busy[1], 0);
    endtask

    task automatic cmp_rx(input int sel);
        check("rx_len", sel, rx[sel].size(), sent.size());
        for (int i = 0; i < sent.size() && i < rx[sel].size(); i++) check("rx_data", sel, rx[sel][i], sent[i]);
    endtask

    task automatic clear_rx();
        rx[0].delete();
        rx[1].delete();
        sent.delete();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, c, st;
        #2 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            check("rst_s_ready", k, s_ready[k], 1);
            check("rst_m_valid", k, m_valid[k], 0);
            check("rst_busy", k, busy[k], 0);
            check("rst_overflow", k, ovf[k], 0);
        end

        // single beat: 4-stage copy shows it 5 cycles later, 1-stage copy 2 cycles later
        repeat (5) step();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step();
        s_valid = 1'b0;
        s_data  = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            check("t1_valid", 0, m_valid[0], i == 5);
            check("t1_valid", 1, m_valid[1], i >= 2);
            if (i < 5) step();
        end
        check("t1_data", 0, m_data[0], 8'hA5);
        check("t1_data", 1, m_data[1], 8'hA5);
        step();
        check("t1_hold", 0, m_valid[0], 1);
        check("t1_hold_data", 0, m_data[0], 8'hA5);
        drain();
        check("t1_rx_len", 0, rx[0].size(), 1);
        if (rx[0].size() != 0) check("t1_rx", 0, rx[0][0], 8'hA5);

        // streaming 0..99 at full rate
        clear_rx();
        stream(0, 100, 100, 100, 1'b0, 8'h00, 1000, n, c, st);
        check("t2_accepted", 0, n, 100);
        check("t2_cycles", 0, c, 100);
        check("t2_stalls", 0, st, 0);
        drain();
        check("t2_rx_len", 0, rx[0].size(), 100);
        for (int i = 0; i < 100 && i < rx[0].size(); i++) check("t2_order", 0, rx[0][i], 32'(i));

        // sink stalled: exactly FIFO_DEPTH credits
        clear_rx();
        stream(0, 100, 100, 0, 1'b0, 8'h10, 20, n, c, st);
        check("t3_accepted", 0, n, 6);
        check("t3_s_ready", 0, s_ready[0], 0);
        check("t3_s_ready", 1, s_ready[1], 0);
        drain();
        cmp_rx(0);
        check("t3_overflow", 0, ovf[0], 0);

        // random valid/ready soak
        clear_rx();
        stream(0, 10000, 70, 50, 1'b1, 8'h00, 80000, n, c, st);
        check("t4_accepted", 0, n, 10000);
        drain();
        cmp_rx(0);
        check("t4_overflow", 0, ovf[0], 0);
        check("t4_overflow", 1, ovf[1], 0);

        // flush with 3 in flight and 2 buffered
        clear_rx();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h50 + i);
            step();
            check("t5_accept", 0, acc_seen[0], 1);
        end
        s_valid = 1'b0;
        step();
        check("t5_pre_busy", 0, busy[0], 1);
        check("t5_pre_valid", 0, m_valid[0], 1);
        check("t5_pre_data", 0, m_data[0], 8'h50);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("t5_busy", k, busy[k], 0);
            check("t5_m_valid", k, m_valid[k], 0);
        end
        clear_rx();
        s_valid = 1'b1;
        s_data  = 8'h3C;
        step();
        check("t5_accept_3c", 0, acc_seen[0], 1);
        drain();
        check("t5_rx_len", 0, rx[0].size(), 1);
        if (rx[0].size() != 0) check("t5_rx", 0, rx[0][0], 8'h3C);

        // asynchronous reset mid-stream, then clean traffic on the 1-stage copy
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("t6_s_ready", k, s_ready[k], 0);
            check("t6_m_valid", k, m_valid[k], 0);
            check("t6_busy", k, busy[k], 0);
            check("t6_overflow", k, ovf[k], 0);
        end
        step();
        rst_n = 1'b1;
        s_valid = 1'b0;
        step();
        clear_rx();
        stream(1, 20, 100, 100, 1'b0, 8'h40, 200, n, c, st);
        check("t6_accepted", 1, n, 20);
        drain();
        cmp_rx(1);
        if (rx[1].size() != 0) check("t6_first", 1, rx[1][0], 8'h40);
        check("t6_overflow_end", 1, ovf[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
